ftoi_pipe: RTL and testbench
============================

Name: ftoi_pipe

Overview:
Single-precision float to signed 32-bit integer converter, the inverse of the FPU's int-to-float path, used by the ftoi instruction. It is a two-stage pipeline with valid/ready handshakes on both sides, so the FPU issue logic can stall it without losing data. Rounding is to nearest with ties away from zero, which matches the magnitude rounding of the int-to-float path. Out-of-range, infinite and NaN inputs saturate and raise a flag.

Parameters:
ROUND, 1, 1 = round to nearest with ties away from zero; 0 = truncate toward zero.

Ports:
clk  input  1  clock; all state changes on its rising edge
rstn  input  1  reset; synchronous, active-low
x  input  32  IEEE-754 single-precision operand
in_valid  input  1  x is valid this cycle
in_ready  output  1  block accepts x this cycle
y  output  32  signed two's-complement result
ovf  output  1  result saturated (|x| >= 2^31 except exactly -2^31, or inf/NaN)
out_valid  output  1  y and ovf are valid
out_ready  input  1  consumer takes y this cycle

Behaviour:
- Reset (rstn=0 at a clk edge): both stage valids clear, out_valid=0, y=0, ovf=0. Reset overrides every other event, including a transfer mid-flight. In-flight data is discarded.
- Transfer rule: input transfer happens when in_valid & in_ready; output transfer happens when out_valid & out_ready.
- Stage valids: v1 is stage 1, v2 is stage 2 (v2 drives out_valid).
- Ready logic: adv2 = ~v2 | out_ready; in_ready = ~v1 | adv2. The pipeline is fully throughput-1 and has no combinational path from in_valid to out_valid.
- Latency: 2 cycles from input transfer to out_valid with no stall. Results leave in input order. No drops, no duplicates.
- While stalled (out_valid & ~out_ready), y and ovf hold stable.
- Stage 1 (align):
  - s = x[31], e = x[30:23], m = {1, x[22:0]}.
  - e < 126: mag = 0, rbit = 0. This covers zero, denormals and |x| < 0.5.
  - 126 <= e <= 149: mag = m >> (150-e), rbit = m[149-e].
  - 150 <= e <= 157: mag = m << (e-150), rbit = 0 (exact result).
  - e >= 158: sat = 1, unless x == 0xCF000000, which is exactly -2^31.
  - Register s, mag[31:0], rbit, sat, and the exact -2^31 marker.
- Stage 2 (round/sign):
  - r = mag + (ROUND & rbit). This cannot overflow 31 bits for e <= 157.
  - y = s ? -r : r.
  - sat: y = s ? 0x80000000 : 0x7FFFFFFF, ovf = 1. NaN follows its sign bit.
  - The -2^31 case gives y = 0x80000000, ovf = 0.
  - -0 gives y = 0, and negative inputs that round to 0 also give y = 0.

Decomposition:
- Shared constants header (fpu_consts): EXP_BIAS=127, FRAC_W=23, EXP_EXACT=150, EXP_SAT=158, INT_MAX=0x7FFFFFFF, INT_MIN=0x80000000.
- One combinational sub-module, ftoi_align. It implements stage 1 decode/shift (x -> s, mag, rbit, sat). The top holds both pipeline registers, the handshake and stage 2.

Test Plan:
- Basic values, out_ready=1, ROUND=1:
  - 0x3FC00000 (1.5) -> 0x00000002 two cycles after accept, ovf=0.
  - 0xC0200000 (-2.5) -> 0xFFFFFFFD.
  - 0x3F000000 (0.5) -> 0x00000001.
  - 0x3EFFFFFF -> 0x00000000.
  - 0x80000000 (-0) -> 0x00000000.
- Saturation:
  - 0x4F000000 -> 0x7FFFFFFF, ovf=1.
  - 0xCF000000 -> 0x80000000, ovf=0.
  - 0x7FC00000 (NaN) -> 0x7FFFFFFF, ovf=1.
  - 0xFF800000 (-inf) -> 0x80000000, ovf=1.
  - 0x4EFFFFFF -> 0x7FFFFF80, ovf=0.
- Back-pressure:
  - Stimulus: in_valid held high with 1.0, 2.0, 3.0, 4.0; out_ready=0 for cycles 2-6.
  - Required: in_ready falls after two accepts; y holds 1 stable during the stall; outputs are 1, 2, 3, 4 in order once out_ready=1, each exactly once.
- Full throughput: 100 random floats back-to-back, out_ready=1 -> one result per cycle, matching a reference model bit-exactly.
- Reset mid-flight: assert rstn=0 for one cycle while v1=v2=1 -> next cycle out_valid=0, y=0, ovf=0, in_ready=1; stale data never appears.
- ROUND=0: 1.5 -> 1; -2.5 -> 0xFFFFFFFE; 0x3F7FFFFF -> 0.

Source files
------------

// File: rtl/ftoi_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ftoi_pipe_pkg
// Purpose  : Shared float-format constants and the stage-1 payload type for
//            the float-to-int converter (fpu_consts).
// Contents : EXP_BIAS, FRAC_W, EXP_EXACT, EXP_SAT, INT_MAX, INT_MIN,
//            X_NEG_2P31, align_t, negate()
// Revision : 1.0 - initial release
// ============================================================================
package ftoi_pipe_pkg;

  localparam int          EXP_BIAS   = 127;
  localparam int          FRAC_W     = 23;
  // Smallest biased exponent whose value has no fractional bits.
  localparam int          EXP_EXACT  = 150;
  // Smallest biased exponent whose magnitude is >= 2^31.
  localparam int          EXP_SAT    = 158;
  localparam logic [31:0] INT_MAX    = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;
  // Single-precision encoding of exactly -2^31, the one in-range value
  // with an exponent of EXP_SAT.
  localparam logic [31:0] X_NEG_2P31 = 32'hCF00_0000;

  // Stage-1 result carried into the stage-1 register.
  typedef struct packed {
    logic        s;     // sign of the operand
    logic [31:0] mag;   // truncated magnitude
    logic        rbit;  // first discarded bit (half-LSB)
    logic        sat;   // out of range, inf or NaN
    logic        min;   // operand is exactly -2^31
  } align_t;

  function automatic logic [31:0] negate(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ftoi_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : ftoi_pipe_if
// Purpose  : Input and output valid/ready streams of the float-to-int pipe.
// Signals  : x, in_valid, in_ready   - operand stream
//            y, ovf, out_valid, out_ready - result stream
// Modports : master - producer of operands / consumer of results
//            slave  - the converter
// Revision : 1.0 - initial release
// ============================================================================
interface ftoi_pipe_if;

  logic [31:0] x;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output x, in_valid, out_ready,
    input  in_ready, y, ovf, out_valid
  );

  modport slave (
    input  x, in_valid, out_ready,
    output in_ready, y, ovf, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/ftoi_align.sv
`default_nettype none
// ============================================================================
// Module   : ftoi_align
// Purpose  : Combinational stage-1 decode of a single-precision operand into
//            sign, truncated integer magnitude, rounding bit and saturation.
// Ports    : x - IEEE-754 single operand
//            a - decoded fields (align_t)
// Revision : 1.0 - initial release
// ============================================================================
module ftoi_align
  import ftoi_pipe_pkg::*;
(
  input  logic [31:0] x,
  output align_t      a
);

  logic [7:0]  e;
  logic [23:0] m;
  logic [7:0]  rsh;
  logic [7:0]  lsh;
  logic [32:0] ext;

  always_comb begin
    e   = x[30:FRAC_W];
    m   = {1'b1, x[FRAC_W-1:0]};
    rsh = 8'(EXP_EXACT) - e;
    lsh = e - 8'(EXP_EXACT);
    // One guard bit is appended below the mantissa so a single right shift
    // yields both the integer part and the first bit shifted out.
    ext = {8'b0, m, 1'b0} >> rsh;

    a   = '0;
    a.s = x[31];
    if (e < 8'(EXP_BIAS - 1)) begin
      // |x| < 0.5, zero and denormals: everything stays zero.
    end else if (e < 8'(EXP_EXACT)) begin
      a.mag  = ext[32:1];
      a.rbit = ext[0];
    end else if (e < 8'(EXP_SAT)) begin
      a.mag = {8'b0, m} << lsh;
    end else if (x == X_NEG_2P31) begin
      a.min = 1'b1;
    end else begin
      a.sat = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ftoi_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ftoi_pipe
// Purpose  : Two-stage float-to-signed-int32 converter with valid/ready on
//            both sides. Stage 1 aligns the mantissa, stage 2 rounds,
//            applies the sign and saturates.
// Params   : ROUND - 1: nearest, ties away from zero; 0: truncate
// Ports    : clk  - clock
//            rstn - synchronous active-low reset
//            bus  - ftoi_pipe_if.slave (x/in_valid/in_ready,
//                   y/ovf/out_valid/out_ready)
// Revision : 1.0 - initial release
// ============================================================================
module ftoi_pipe
  import ftoi_pipe_pkg::*;
#(
  parameter bit ROUND = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  ftoi_pipe_if.slave  bus
);

  align_t      align_out;
  align_t      s1_d, s1_q;
  logic        v1_d, v1_q;
  logic        v2_d, v2_q;
  logic [31:0] y_d, y_q;
  logic        ovf_d, ovf_q;

  logic        adv2;
  logic        in_rdy;
  logic [31:0] r;
  logic [31:0] y_nx;
  logic        ovf_nx;

  ftoi_align u_align (
    .x (bus.x),
    .a (align_out)
  );

  // Handshake: stage 2 may advance when empty or drained this cycle, and
  // stage 1 may accept when empty or moving into stage 2.
  always_comb begin
    adv2   = ~v2_q | bus.out_ready;
    in_rdy = ~v1_q | adv2;
    v1_d   = in_rdy ? bus.in_valid : v1_q;
    s1_d   = (in_rdy & bus.in_valid) ? align_out : s1_q;
    v2_d   = adv2 ? v1_q : v2_q;
  end

  // Stage 2: round, sign, saturate.
  always_comb begin
    // mag < 2^31 whenever sat/min are clear, so the increment cannot wrap.
    r      = s1_q.mag + {31'b0, ROUND & s1_q.rbit};
    y_nx   = s1_q.s ? negate(r) : r;
    ovf_nx = 1'b0;
    if (s1_q.sat) begin
      y_nx   = s1_q.s ? INT_MIN : INT_MAX;
      ovf_nx = 1'b1;
    end else if (s1_q.min) begin
      y_nx   = INT_MIN;
    end

    // Result registers only change on a real stage-2 load, so y/ovf hold
    // while stalled and after bubbles.
    y_d   = y_q;
    ovf_d = ovf_q;
    if (adv2 & v1_q) begin
      y_d   = y_nx;
      ovf_d = ovf_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q  <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      y_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      y_q   <= y_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = v2_q;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ftoi_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ftoi_pipe
// Purpose  : Scoreboard bench for ftoi_pipe. Two instances (ROUND=1 and
//            ROUND=0) share one operand stream and one out_ready; each has
//            its own queue of expected results, drained by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ftoi_pipe;

  typedef struct {
    logic [31:0] y;
    logic        ovf;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ftoi_pipe_if if1 ();
  ftoi_pipe_if if0 ();

  assign if0.x         = if1.x;
  assign if0.in_valid  = if1.in_valid;
  assign if0.out_ready = if1.out_ready;

  ftoi_pipe #(.ROUND(1'b1)) u_dut_rnd (.clk(clk), .rstn(rstn), .bus(if1));
  ftoi_pipe #(.ROUND(1'b0)) u_dut_trc (.clk(clk), .rstn(rstn), .bus(if0));

  exp_t q1[$];
  exp_t q0[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Reference: build the real value from the fields and round it.
  function automatic void model(input logic [31:0] x, input bit rnd,
                                output logic [31:0] y, output logic ovf);
    real a;
    real r;
    int  e;
    int  m;
    e   = int'(x[30:23]);
    ovf = 1'b0;
    y   = 32'd0;
    if (x == 32'hCF00_0000) begin
      y = 32'h8000_0000;
    end else if (e == 255) begin
      y   = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      ovf = 1'b1;
    end else begin
      if (e == 0) a = 0.0;
      else a = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
      r = rnd ? $floor(a + 0.5) : $floor(a);
      if (r >= 2147483648.0) begin
        y   = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        ovf = 1'b1;
      end else begin
        m = $rtoi(r);
        y = x[31] ? 32'(-m) : 32'(m);
      end
    end
  endfunction

  task automatic send(input logic [31:0] x,
                      input logic [31:0] y1, input logic o1,
                      input logic [31:0] y0, input logic o0);
    exp_t e1;
    exp_t e0;
    bit   done;
    done    = 1'b0;
    e1.y    = y1; e1.ovf = o1;
    e0.y    = y0; e0.ovf = o0;
    if1.x        = x;
    if1.in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (if1.in_ready) begin
        q1.push_back(e1);
        q0.push_back(e0);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if1.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: x=0x%08h not accepted in 50 cycles, required accept", x);
    end
  endtask

  task automatic monitor_step();
    exp_t e;
    if (rstn && if1.out_valid && if1.out_ready) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rnd_unexpected: got y=0x%08h, required no output", if1.y);
      end else begin
        e = q1.pop_front();
        check("rnd_y", if1.y, e.y);
        check("rnd_ovf", 32'(if1.ovf), 32'(e.ovf));
      end
    end
    if (rstn && if0.out_valid && if0.out_ready) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL trc_unexpected: got y=0x%08h, required no output", if0.y);
      end else begin
        e = q0.pop_front();
        check("trc_y", if0.y, e.y);
        check("trc_ovf", 32'(if0.ovf), 32'(e.ovf));
      end
    end
  endtask

  // Directed vectors: x, ROUND=1 y/ovf, ROUND=0 y/ovf.
  localparam int ND = 11;
  logic [31:0] dx  [ND] = '{32'hC020_0000, 32'h3F00_0000, 32'h3EFF_FFFF, 32'h8000_0000,
                            32'h4F00_0000, 32'hCF00_0000, 32'h7FC0_0000, 32'hFF80_0000,
                            32'h4EFF_FFFF, 32'h3F7F_FFFF, 32'hBF7F_FFFF};
  logic [31:0] dy1 [ND] = '{32'hFFFF_FFFD, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000,
                            32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                            32'h7FFF_FF80, 32'h0000_0001, 32'hFFFF_FFFF};
  logic        do1 [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] dy0 [ND] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                            32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                            32'h7FFF_FF80, 32'h0000_0000, 32'h0000_0000};

  initial begin
    logic [31:0] rx;
    logic [31:0] ry1;
    logic [31:0] ry0;
    logic        ro1;
    logic        ro0;
    longint      t0;

    if1.x         = 32'd0;
    if1.in_valid  = 1'b0;
    if1.out_ready = 1'b1;
    rstn          = 1'b0;

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    check("rst_out_valid", 32'(if1.out_valid), 32'd0);
    check("rst_y", if1.y, 32'd0);
    check("rst_ovf", 32'(if1.ovf), 32'd0);
    check("rst_in_ready", 32'(if1.in_ready), 32'd1);
    check("rst_trc_out_valid", 32'(if0.out_valid), 32'd0);

    // 1.5 with explicit latency check.
    send(32'h3FC0_0000, 32'd2, 1'b0, 32'd1, 1'b0);
    check("lat_stage1_not_out", 32'(if1.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_out_valid", 32'(if1.out_valid), 32'd1);
    check("lat_y", if1.y, 32'd2);

    for (int i = 0; i < ND; i++) send(dx[i], dy1[i], do1[i], dy0[i], 1'b0 | do1[i]);
    repeat (4) @(posedge clk); #1;

    // Back-pressure: out_ready low while 1.0..4.0 are offered.
    if1.out_ready = 1'b0;
    fork
      begin
        send(32'h3F80_0000, 32'd1, 1'b0, 32'd1, 1'b0);
        send(32'h4000_0000, 32'd2, 1'b0, 32'd2, 1'b0);
        send(32'h4040_0000, 32'd3, 1'b0, 32'd3, 1'b0);
        send(32'h4080_0000, 32'd4, 1'b0, 32'd4, 1'b0);
      end
      begin
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          if (if1.out_valid) check("stall_y_hold", if1.y, 32'd1);
        end
        check("stall_in_ready_low", 32'(if1.in_ready), 32'd0);
        check("stall_out_valid", 32'(if1.out_valid), 32'd1);
        @(posedge clk);
        #1 if1.out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    check("bp_drained", 32'(q1.size()), 32'd0);

    // Full throughput, random operands against the model.
    t0 = $time;
    for (int i = 0; i < 100; i++) begin
      rx = {1'($urandom), 8'($urandom_range(100, 165)), 23'($urandom)};
      if (i % 10 == 9) rx[30:23] = 8'hFF;
      model(rx, 1'b1, ry1, ro1);
      model(rx, 1'b0, ry0, ro0);
      send(rx, ry1, ro1, ry0, ro0);
    end
    check("tput_cycles", 32'(($time - t0) / 10), 32'd100);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("tput_drained_rnd", 32'(q1.size()), 32'd0);
    check("tput_drained_trc", 32'(q0.size()), 32'd0);
    repeat (2) @(posedge clk); #1;

    // Reset with both stages full.
    if1.out_ready = 1'b0;
    send(32'h3F80_0000, 32'd1, 1'b0, 32'd1, 1'b0);
    send(32'h4000_0000, 32'd2, 1'b0, 32'd2, 1'b0);
    check("mid_full_out_valid", 32'(if1.out_valid), 32'd1);
    rstn = 1'b0;
    q1.delete();
    q0.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    check("mid_rst_out_valid", 32'(if1.out_valid), 32'd0);
    check("mid_rst_y", if1.y, 32'd0);
    check("mid_rst_ovf", 32'(if1.ovf), 32'd0);
    check("mid_rst_in_ready", 32'(if1.in_ready), 32'd1);
    if1.out_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("mid_rst_no_stale", 32'(if1.out_valid), 32'd0);
    check("end_queue_rnd", 32'(q1.size()), 32'd0);
    check("end_queue_trc", 32'(q0.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
